design_mux_ctrl: RTL and testbench

//  Parametrised successor to the single-design user-project wrapper: hosts NUM_DESIGNS designs behind one Caravel IO/WB port.

---
 rtl/design_mux_pkg.sv | 25 ++
 rtl/design_mux_if.sv | 21 ++
 rtl/design_mux_wb_regs.sv | 82 ++++++++
 rtl/design_mux_ctrl.sv | 161 ++++++++++++++++
 tb/tb_design_mux_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/design_mux_pkg.sv
// Shared types and register map for the multi-design pad multiplexer.
// FSM states, WB register offsets and bit positions used by the regs block and the top.
package design_mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISOLATE = 2'd1,
        HOLD    = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam int SEL_W     = 8;
    localparam int EXT_SEL_W = 5;
    localparam int CNT_BITS  = 8;

    localparam logic [31:0] CTRL_OFS   = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    localparam int CTRL_EN_BIT    = 31;
    localparam int STAT_BUSY_BIT  = 8;
    localparam int STAT_ERR_BIT   = 9;
    localparam int STAT_STRAP_BIT = 10;
    localparam int STAT_CNT_LSB   = 16;

endpackage

// File: rtl/design_mux_if.sv
// Wishbone slave bus between the Caravel management core and the design multiplexer.
interface design_mux_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/design_mux_wb_regs.sv
// WB decode for the multiplexer: single-cycle ack, CTRL/STATUS registers, sticky err, pending selection.
// When the external strap is active the synced ext_sel drives pend_sel instead of CTRL writes.
module design_mux_wb_regs
    import design_mux_pkg::*;
#(
    parameter int          NUM_DESIGNS = 16,
    parameter logic [31:0] WB_BASE     = 32'h3000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    design_mux_if.slave          wb,
    input  logic [SEL_W-1:0]     cur_sel,
    input  logic                 busy,
    input  logic [CNT_BITS-1:0]  sw_cnt,
    input  logic                 strap,
    input  logic [EXT_SEL_W-1:0] ext_sel,
    output logic                 en,
    output logic [SEL_W-1:0]     pend_sel,
    output logic                 err
);

    localparam logic [SEL_W:0] NUM_D = (SEL_W+1)'(NUM_DESIGNS);

    function automatic logic in_range(input logic [SEL_W-1:0] s);
        return {1'b0, s} < NUM_D;
    endfunction

    logic        hit_ctrl, hit_stat, acc;
    logic        wr_ctrl, wr_stat, sel_byte, bad_sel, ext_bad;
    logic [31:0] ctrl_rd, stat_rd;
    logic        unused_wb;

    assign hit_ctrl = wb.wbs_adr_i == (WB_BASE + CTRL_OFS);
    assign hit_stat = wb.wbs_adr_i == (WB_BASE + STATUS_OFS);
    // The !ack term keeps a held strobe from producing a second, back-to-back ack.
    assign acc      = wb.wbs_cyc_i & wb.wbs_stb_i & (hit_ctrl | hit_stat) & ~wb.wbs_ack_o;
    assign wr_ctrl  = acc & wb.wbs_we_i & hit_ctrl;
    assign wr_stat  = acc & wb.wbs_we_i & hit_stat;
    assign sel_byte = wb.wbs_sel_i[0] & ~strap;
    assign bad_sel  = wr_ctrl & sel_byte & ~in_range(wb.wbs_dat_i[SEL_W-1:0]);
    assign ext_bad  = strap & ~in_range(SEL_W'(ext_sel));

    assign unused_wb = ^{wb.wbs_dat_i[30:10], wb.wbs_dat_i[8], wb.wbs_sel_i[2]};

    always_comb begin
        ctrl_rd                 = '0;
        ctrl_rd[SEL_W-1:0]      = pend_sel;
        ctrl_rd[CTRL_EN_BIT]    = en;
        stat_rd                 = '0;
        stat_rd[SEL_W-1:0]      = cur_sel;
        stat_rd[STAT_BUSY_BIT]  = busy;
        stat_rd[STAT_ERR_BIT]   = err;
        stat_rd[STAT_STRAP_BIT] = strap;
        stat_rd[STAT_CNT_LSB +: CNT_BITS] = sw_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
            en           <= 1'b0;
            pend_sel     <= '0;
            err          <= 1'b0;
        end else begin
            wb.wbs_ack_o <= acc;
            wb.wbs_dat_o <= '0;
            if (acc && !wb.wbs_we_i)
                wb.wbs_dat_o <= hit_ctrl ? ctrl_rd : stat_rd;
            if (wr_ctrl && !bad_sel) begin
                if (sel_byte)          pend_sel <= wb.wbs_dat_i[SEL_W-1:0];
                if (wb.wbs_sel_i[3])   en       <= wb.wbs_dat_i[CTRL_EN_BIT];
            end
            if (strap && !ext_bad)
                pend_sel <= SEL_W'(ext_sel);
            if (wr_stat && wb.wbs_sel_i[1] && wb.wbs_dat_i[STAT_ERR_BIT])
                err <= 1'b0;
            if (bad_sel || ext_bad)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/design_mux_ctrl.sv
// Hosts NUM_DESIGNS user designs behind one pad ring; a switch FSM isolates, resets and releases them in turn.
// Optional `EXT_SEL_EN: pad strap + 5-bit ext_sel (2-flop synchronised) override the WB selection.
module design_mux_ctrl
    import design_mux_pkg::*;
#(
    parameter int          NUM_DESIGNS     = 16,
    parameter int          IO_W            = 38,
    parameter int          RST_HOLD_CYCLES = 8,
    parameter logic [31:0] WB_BASE         = 32'h3000_0000
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    design_mux_if.slave                 wb,
    input  logic [IO_W-1:0]             io_in,
    output logic [IO_W-1:0]             io_out,
    output logic [IO_W-1:0]             io_oeb,
    input  logic [NUM_DESIGNS*IO_W-1:0] des_io_out,
    input  logic [NUM_DESIGNS*IO_W-1:0] des_io_oeb,
    output logic [NUM_DESIGNS-1:0]      des_rst_o
);

    localparam int IDX_W = (NUM_DESIGNS > 1) ? $clog2(NUM_DESIGNS) : 1;
    localparam int CNT_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);

    state_t                state, state_nxt;
    logic [SEL_W-1:0]      cur_sel, cur_sel_nxt, pend_sel;
    logic [CNT_W-1:0]      hold_cnt, hold_cnt_nxt;
    logic [CNT_BITS-1:0]   sw_cnt, sw_cnt_nxt;
    logic                  en, err, busy, strap;
    logic [EXT_SEL_W-1:0]  ext_sel;
    logic [NUM_DESIGNS-1:0] rst_nxt;
    logic [IO_W-1:0]       out_sl [NUM_DESIGNS];
    logic [IO_W-1:0]       oeb_sl [NUM_DESIGNS];
    logic                  unused_io;

`ifdef EXT_SEL_EN
    logic [EXT_SEL_W:0] ext_s1, ext_s2;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ext_s1 <= '0;
            ext_s2 <= '0;
        end else begin
            ext_s1 <= io_in[IO_W-1 -: EXT_SEL_W+1];
            ext_s2 <= ext_s1;
        end
    end

    assign strap     = ext_s2[EXT_SEL_W];
    assign ext_sel   = ext_s2[EXT_SEL_W-1:0];
    assign unused_io = ^io_in[IO_W-EXT_SEL_W-2:0];
`else
    assign strap     = 1'b0;
    assign ext_sel   = '0;
    assign unused_io = ^io_in;
`endif

    design_mux_wb_regs #(
        .NUM_DESIGNS (NUM_DESIGNS),
        .WB_BASE     (WB_BASE)
    ) u_regs (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .wb       (wb),
        .cur_sel  (cur_sel),
        .busy     (busy),
        .sw_cnt   (sw_cnt),
        .strap    (strap),
        .ext_sel  (ext_sel),
        .en       (en),
        .pend_sel (pend_sel),
        .err      (err)
    );

    assign busy = (state == ISOLATE) || (state == HOLD);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            cur_sel  <= '0;
            hold_cnt <= '0;
            sw_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            cur_sel  <= cur_sel_nxt;
            hold_cnt <= hold_cnt_nxt;
            sw_cnt   <= sw_cnt_nxt;
        end
    end

    // A re-pass after HOLD counts as a switch, as does leaving RUN; starting from IDLE does not.
    always_comb begin
        state_nxt    = state;
        cur_sel_nxt  = cur_sel;
        hold_cnt_nxt = hold_cnt;
        sw_cnt_nxt   = sw_cnt;
        case (state)
            IDLE: if (en) state_nxt = ISOLATE;
            ISOLATE: begin
                cur_sel_nxt  = pend_sel;
                hold_cnt_nxt = '0;
                state_nxt    = HOLD;
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    if (!en) begin
                        state_nxt = IDLE;
                    end else if (pend_sel != cur_sel) begin
                        state_nxt  = ISOLATE;
                        sw_cnt_nxt = sw_cnt + 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (pend_sel != cur_sel) begin
                    state_nxt  = ISOLATE;
                    sw_cnt_nxt = sw_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rst_nxt = '1;
        for (int d = 0; d < NUM_DESIGNS; d++)
            if (state_nxt == RUN && cur_sel_nxt == SEL_W'(d))
                rst_nxt[d] = 1'b0;
    end

    for (genvar d = 0; d < NUM_DESIGNS; d++) begin : g_slice
        assign out_sl[d] = des_io_out[d*IO_W +: IO_W];
        assign oeb_sl[d] = des_io_oeb[d*IO_W +: IO_W];
    end

    // Outputs follow state_nxt so pads are isolated on the very edge that leaves RUN.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            io_out    <= '0;
            io_oeb    <= '1;
            des_rst_o <= '1;
        end else begin
            des_rst_o <= rst_nxt;
            if (state_nxt == RUN) begin
                io_out <= out_sl[cur_sel[IDX_W-1:0]];
                io_oeb <= oeb_sl[cur_sel[IDX_W-1:0]];
            end else begin
                io_out <= '0;
                io_oeb <= '1;
            end
        end
    end

endmodule

// File: tb/tb_design_mux_ctrl.sv
// Directed bench for design_mux_ctrl: WB access, switch sequencing, err handling, reset mid-switch.
module tb_design_mux_ctrl;

    localparam int          ND   = 16;
    localparam int          IOW  = 38;
    localparam logic [31:0] CTRL = 32'h3000_0000;
    localparam logic [31:0] STAT = 32'h3000_0004;
    localparam logic [37:0] OEB_ALL = 38'h3F_FFFF_FFFF;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [IOW-1:0]      io_in = '0;
    logic [IOW-1:0]      io_out, io_oeb;
    logic [ND*IOW-1:0]   des_io_out, des_io_oeb;
    logic [ND-1:0]       des_rst_o;
    int                  n_tests = 0;
    int                  n_fail  = 0;
    logic                overlap = 1'b0;

    design_mux_if wb ();

    design_mux_ctrl #(
        .NUM_DESIGNS     (ND),
        .IO_W            (IOW),
        .RST_HOLD_CYCLES (8),
        .WB_BASE         (32'h3000_0000)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb         (wb),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .des_io_out (des_io_out),
        .des_io_oeb (des_io_oeb),
        .des_rst_o  (des_rst_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if ($countones(~des_rst_o) > 1) overlap = 1'b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                        input logic [3:0] sel, output logic [31:0] rd, output int lat);
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_sel_i = sel;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        lat = 0;
        rd  = '0;
        for (int i = 1; i <= 4 && lat == 0; i++) begin
            @(negedge clk);
            if (wb.wbs_ack_o === 1'b1) begin
                lat = i;
                rd  = wb.wbs_dat_o;
            end
        end
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        @(negedge clk);
        chk("ack_single", 64'(wb.wbs_ack_o), 64'd0);
        chk("dat_idle", 64'(wb.wbs_dat_o), 64'd0);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input string tag);
        logic [31:0] d;
        int          lat;
        xfer(adr, dat, 1'b1, sel, d, lat);
        chk({tag, "_ack"}, 64'(lat), 64'd1);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        int          lat;
        xfer(adr, 32'h0, 1'b0, 4'hF, d, lat);
        chk({tag, "_ack"}, 64'(lat), 64'd1);
        chk(tag, 64'(d), 64'(exp));
    endtask

    task automatic wait_rel(input logic [15:0] exp, input string tag);
        int n = 0;
        while (des_rst_o === 16'hFFFF && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(des_rst_o), 64'(exp));
    endtask

    initial begin
        logic        early;
        logic        changed;
        logic [31:0] d;
        int          lat;

        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;
        for (int k = 0; k < ND; k++) begin
            des_io_out[k*IOW +: IOW] = 38'h2_0000_0000 | 38'(k);
            des_io_oeb[k*IOW +: IOW] = ~(38'd1 << k);
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_des_rst", 64'(des_rst_o), 64'hFFFF);
        chk("rst_io_oeb", 64'(io_oeb), 64'(OEB_ALL));
        chk("rst_io_out", 64'(io_out), 64'd0);
        chk("rst_ack", 64'(wb.wbs_ack_o), 64'd0);
        rd(STAT, 32'h0000_0000, "rst_status");
        rd(CTRL, 32'h0000_0000, "rst_ctrl");

        // Enable design 3: 1 ISOLATE + 8 HOLD cycles, then release
        wr(CTRL, 32'h8000_0003, 4'hF, "en3");
        early = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (des_rst_o !== 16'hFFFF || io_oeb !== OEB_ALL) early = 1'b1;
            @(negedge clk);
        end
        chk("hold_isolated", 64'(early), 64'd0);
        chk("run3_des_rst", 64'(des_rst_o), 64'hFFF7);
        chk("run3_io_out", 64'(io_out), 64'h2_0000_0003);
        chk("run3_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFF7);
        des_io_out[3*IOW +: IOW] = 38'h1_2345_6789;
        #1;
        chk("io_out_lag", 64'(io_out), 64'h2_0000_0003);
        @(negedge clk);
        chk("io_out_follow", 64'(io_out), 64'h1_2345_6789);

        // Switch to 5, then 7 while HOLD is still running
        wr(CTRL, 32'h8000_0005, 4'hF, "sel5");
        chk("iso_des_rst", 64'(des_rst_o), 64'hFFFF);
        chk("iso_io_oeb", 64'(io_oeb), 64'(OEB_ALL));
        chk("iso_io_out", 64'(io_out), 64'd0);
        wr(CTRL, 32'h8000_0007, 4'hF, "sel7");
        rd(STAT, 32'h0001_0105, "status_busy");
        wait_rel(16'hFF7F, "run7_des_rst");
        chk("run7_io_out", 64'(io_out), 64'h2_0000_0007);
        rd(STAT, 32'h0002_0007, "status_run7");

        // Out-of-range selection and err clear
        wr(CTRL, 32'h8000_0014, 4'hF, "sel20");
        rd(STAT, 32'h0002_0207, "status_err");
        rd(CTRL, 32'h8000_0007, "ctrl_after_bad");
        chk("bad_keeps_run", 64'(des_rst_o), 64'hFF7F);
        wr(STAT, 32'h0000_0200, 4'hF, "err_clr");
        rd(STAT, 32'h0002_0007, "status_err_clr");

        // Same selection again is a no-op
        wr(CTRL, 32'h8000_0007, 4'hF, "same7");
        changed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (des_rst_o !== 16'hFF7F) changed = 1'b1;
            @(negedge clk);
        end
        chk("same_no_pulse", 64'(changed), 64'd0);
        rd(STAT, 32'h0002_0007, "same_sw_cnt");

        // Byte select: only the en byte is written
        wr(CTRL, 32'h0000_0003, 4'b1000, "en_off");
        chk("idle_des_rst", 64'(des_rst_o), 64'hFFFF);
        rd(CTRL, 32'h0000_0007, "ctrl_bytesel");
        wr(CTRL, 32'h8000_0009, 4'b1000, "en_on");
        wait_rel(16'hFF7F, "reenable_des_rst");
        rd(STAT, 32'h0002_0007, "reenable_status");

        // Address miss is never acked
        xfer(32'h3000_0008, 32'h8000_0001, 1'b1, 4'hF, d, lat);
        chk("miss_noack", 64'(lat), 64'd0);
        rd(CTRL, 32'h8000_0007, "miss_no_write");

        // Held strobe gets one ack only
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'hF;
        wb.wbs_adr_i = STAT;
        @(negedge clk);
        chk("held_ack1", 64'(wb.wbs_ack_o), 64'd1);
        @(negedge clk);
        chk("held_ack_drop", 64'(wb.wbs_ack_o), 64'd0);
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        @(negedge clk);

        // Reset asserted during HOLD with an ack on the bus
        wr(CTRL, 32'h8000_0003, 4'hF, "sel3_again");
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = STAT;
        @(negedge clk);
        chk("pre_rst_ack", 64'(wb.wbs_ack_o), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_des_rst", 64'(des_rst_o), 64'hFFFF);
        chk("midrst_io_oeb", 64'(io_oeb), 64'(OEB_ALL));
        chk("midrst_io_out", 64'(io_out), 64'd0);
        chk("midrst_ack", 64'(wb.wbs_ack_o), 64'd0);
        chk("midrst_dat", 64'(wb.wbs_dat_o), 64'd0);
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(STAT, 32'h0000_0000, "post_rst_status");
        rd(CTRL, 32'h0000_0000, "post_rst_ctrl");
        chk("post_rst_des_rst", 64'(des_rst_o), 64'hFFFF);

`ifdef EXT_SEL_EN
        // External strap selects design 2; CTRL sel is ignored but en is honoured
        io_in[37]    = 1'b1;
        io_in[36:32] = 5'd2;
        repeat (3) @(negedge clk);
        wr(CTRL, 32'h8000_0004, 4'hF, "ext_en");
        wait_rel(16'hFFFB, "ext_run2");
        rd(STAT, 32'h0000_0402, "ext_status");
        rd(CTRL, 32'h8000_0002, "ext_ctrl");
        io_in[36:32] = 5'd20;
        repeat (3) @(negedge clk);
        rd(STAT, 32'h0000_0602, "ext_bad_err");
        chk("ext_bad_keeps", 64'(des_rst_o), 64'hFFFB);
`endif

        chk("no_dual_release", 64'(overlap), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
